// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register feeding the ALU, with operand forwarding, stall refresh and flush.
// Define ID_EX_WB_FWD_EN to add MEM/WB forwarding below EX/MEM priority.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_op1_sel,
    input  logic              id_op2_sel,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              mem_fwd_valid,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_op,
    output logic [XLEN-1:0]   ex_operand1,
    output logic [XLEN-1:0]   ex_operand2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic [XLEN-1:0]   ex_pc
);
    localparam logic [3:0] ALU_ADD = 4'd0;

    logic              valid_q, valid_d, rw_q, rw_d, op1_sel_q, op1_sel_d, op2_sel_q, op2_sel_d;
    logic [3:0]        alu_q, alu_d;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d, sd_q, sd_d, pc_q, pc_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic              bubble, load;
    logic [XLEN-1:0]   sd_load, sd_hold;

`ifndef ID_EX_WB_FWD_EN
    logic unused_wb;
    assign unused_wb = ^{wb_fwd_valid, wb_fwd_rd, wb_fwd_data};
`endif

    // x0 never forwards; EX/MEM wins over MEM/WB
    function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] rf);
        if (a == '0) fwd = '0;
        else if (mem_fwd_valid && mem_fwd_rd == a) fwd = mem_fwd_data;
`ifdef ID_EX_WB_FWD_EN
        else if (wb_fwd_valid && wb_fwd_rd == a) fwd = wb_fwd_data;
`endif
        else fwd = rf;
    endfunction

    always_comb begin
        bubble    = flush || (!stall && !id_valid);
        load      = !flush && !stall && id_valid;
        sd_load   = fwd(id_rs2_addr, id_rs2_data);
        sd_hold   = valid_q ? fwd(rs2_q, sd_q) : sd_q;
        valid_d   = bubble ? 1'b0 : load ? 1'b1 : valid_q;
        rw_d      = bubble ? 1'b0 : load ? id_reg_write : rw_q;
        alu_d     = bubble ? ALU_ADD : load ? id_alu_op : alu_q;
        rd_d      = bubble ? '0 : load ? id_rd_addr : rd_q;
        pc_d      = bubble ? '0 : load ? id_pc : pc_q;
        rs1_d     = bubble ? '0 : load ? id_rs1_addr : rs1_q;
        rs2_d     = bubble ? '0 : load ? id_rs2_addr : rs2_q;
        op1_sel_d = bubble ? 1'b0 : load ? id_op1_sel : op1_sel_q;
        op2_sel_d = bubble ? 1'b0 : load ? id_op2_sel : op2_sel_q;
        op1_d     = bubble ? '0 : load ? (id_op1_sel ? id_pc : fwd(id_rs1_addr, id_rs1_data))
                  : (valid_q && !op1_sel_q) ? fwd(rs1_q, op1_q) : op1_q;
        sd_d      = bubble ? '0 : load ? sd_load : sd_hold;
        op2_d     = bubble ? '0 : load ? (id_op2_sel ? id_imm : sd_load)
                  : (valid_q && !op2_sel_q) ? sd_hold : op2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rw_q      <= 1'b0;
            alu_q     <= ALU_ADD;
            op1_q     <= '0;
            op2_q     <= '0;
            sd_q      <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            op1_sel_q <= 1'b0;
            op2_sel_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rw_q      <= rw_d;
            alu_q     <= alu_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            sd_q      <= sd_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            op1_sel_q <= op1_sel_d;
            op2_sel_q <= op2_sel_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_reg_write  = rw_q & valid_q;
    assign ex_alu_op     = alu_q;
    assign ex_operand1   = op1_q;
    assign ex_operand2   = op2_q;
    assign ex_store_data = sd_q;
    assign ex_rd_addr    = rd_q;
    assign ex_pc         = pc_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed checks of load, forwarding, stall refresh, flush and async reset.
module tb_id_ex_operand_stage;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [3:0]  id_alu_op = '0;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0, mem_fwd_rd = '0, wb_fwd_rd = '0;
    logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_pc = '0, id_imm = '0, mem_fwd_data = '0, wb_fwd_data = '0;
    logic        id_op1_sel = 1'b0, id_op2_sel = 1'b0, id_reg_write = 1'b0, mem_fwd_valid = 1'b0, wb_fwd_valid = 1'b0;
    logic        ex_valid, ex_reg_write;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_operand1, ex_operand2, ex_store_data, ex_pc;
    logic [4:0]  ex_rd_addr;
    int          n_chk = 0, n_err = 0;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_pc(id_pc), .id_imm(id_imm),
        .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd),
        .wb_fwd_data(wb_fwd_data), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_alu", 32'(ex_alu_op), 32'(ALU_ADD));
        check("rst_op1", ex_operand1, 32'd0);
        rst_n = 1'b1;
        // plain load
        id_valid = 1; id_alu_op = ALU_SUB; id_rs1_addr = 1; id_rs1_data = 5;
        id_rs2_addr = 2; id_rs2_data = 7; id_rd_addr = 9; id_reg_write = 1; id_pc = 32'h40;
        step();
        check("ld_valid", 32'(ex_valid), 32'd1);
        check("ld_op1", ex_operand1, 32'd5);
        check("ld_op2", ex_operand2, 32'd7);
        check("ld_sd", ex_store_data, 32'd7);
        check("ld_alu", 32'(ex_alu_op), 32'(ALU_SUB));
        check("ld_rd", 32'(ex_rd_addr), 32'd9);
        check("ld_rw", 32'(ex_reg_write), 32'd1);
        check("ld_pc", ex_pc, 32'h40);
        // forward priority
        id_rs1_addr = 3; id_rs1_data = 32'h1111;
        mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'hAAAA;
        wb_fwd_valid = 1; wb_fwd_rd = 3; wb_fwd_data = 32'hBBBB;
        step();
        check("fwd_mem", ex_operand1, 32'hAAAA);
        mem_fwd_valid = 0;
        step();
`ifdef ID_EX_WB_FWD_EN
        check("fwd_wb", ex_operand1, 32'hBBBB);
`else
        check("fwd_wb", ex_operand1, 32'h1111);
`endif
        id_rs1_addr = 0; mem_fwd_valid = 1; mem_fwd_rd = 0; wb_fwd_rd = 0;
        step();
        check("fwd_x0", ex_operand1, 32'd0);
        // pc / imm select with forwarded rs2
        wb_fwd_valid = 0; id_op1_sel = 1; id_op2_sel = 1; id_pc = 32'h100; id_imm = 32'hFFFFFFFC;
        id_rs2_addr = 6; id_rs2_data = 5; mem_fwd_rd = 6; mem_fwd_data = 32'h42;
        step();
        check("sel_op1", ex_operand1, 32'h100);
        check("sel_op2", ex_operand2, 32'hFFFFFFFC);
        check("sel_sd", ex_store_data, 32'h42);
        // stall refresh
        id_op1_sel = 0; id_op2_sel = 0; mem_fwd_valid = 0; id_rs1_addr = 1; id_rs1_data = 32'h10;
        id_rs2_addr = 4; id_rs2_data = 1; id_rd_addr = 7; id_pc = 32'h200;
        step();
        check("st_ld_op2", ex_operand2, 32'd1);
        stall = 1; id_rs1_data = 32'hDEAD; id_rs2_data = 32'hBEEF; id_pc = 32'h999; id_rd_addr = 3;
        step();
        check("st1_op2", ex_operand2, 32'd1);
        check("st1_pc", ex_pc, 32'h200);
        mem_fwd_valid = 1; mem_fwd_rd = 4; mem_fwd_data = 32'h99;
        step();
        check("st2_op2", ex_operand2, 32'h99);
        check("st2_sd", ex_store_data, 32'h99);
        check("st2_op1", ex_operand1, 32'h10);
        check("st2_pc", ex_pc, 32'h200);
        check("st2_rd", 32'(ex_rd_addr), 32'd7);
        check("st2_valid", 32'(ex_valid), 32'd1);
        // flush beats stall
        mem_fwd_valid = 0; flush = 1;
        step();
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_rw", 32'(ex_reg_write), 32'd0);
        check("fl_op1", ex_operand1, 32'd0);
        check("fl_op2", ex_operand2, 32'd0);
        check("fl_sd", ex_store_data, 32'd0);
        check("fl_alu", 32'(ex_alu_op), 32'(ALU_ADD));
        // async reset mid-stream
        flush = 0; stall = 0; id_rs1_data = 5;
        step();
        check("ar_pre_valid", 32'(ex_valid), 32'd1);
        #2 rst_n = 0;
        #1;
        check("ar_valid", 32'(ex_valid), 32'd0);
        check("ar_op1", ex_operand1, 32'd0);
        check("ar_alu", 32'(ex_alu_op), 32'(ALU_ADD));
        check("ar_pc", ex_pc, 32'd0);
        id_valid = 0; rst_n = 1;
        step();
        check("ar_post_valid", 32'(ex_valid), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
